event_apb_master_rr: RTL
========================

# event_apb_master_rr

Parametrised event-to-APB write master: NUM_EVENTS single-bit event inputs each own a saturating pending counter, and a round-robin arbiter turns pending events into APB write transactions to one slave. Each write goes to a per-channel address and carries the number of events coalesced since that channel's last write. It replaces the fixed three-event converter at the same point in the design: event sources on one side, a single APB slave port on the other.

## Interface
- NUM_EVENTS, 3: number of event channels, 1..16
- CNT_W, 4: pending counter width; saturates at 2^CNT_W-1
- ADDR_BASE, 32'h0000_ABC0: address of channel 0
- ADDR_STRIDE, 32'h4: address increment per channel

Ports:
- clk  in  1  clock; all flops positive-edge
- reset  in  1  asynchronous, active-high
- event_i  in  NUM_EVENTS  event pulses, one bit per channel, sampled every cycle
- apb_psel_o  out  1  APB select
- apb_penable_o  out  1  APB enable
- apb_paddr_o  out  32  ADDR_BASE + ch*ADDR_STRIDE
- apb_pwrite_o  out  1  always 1 while apb_psel_o=1, else 0
- apb_pwdata_o  out  32  zero-extended coalesced count
- apb_pready_i  in  1  slave ready
- ovf_o  out  NUM_EVENTS  sticky per-channel overflow; cleared only by reset

## Operation
- Pending counter cnt[k] for each channel.
  - Increments on each cycle where event_i[k]=1.
  - Saturates at max. An event arriving at max sets ovf_o[k].
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, or ACCESS completing (pready=1):
  - If any cnt!=0, the round-robin arbiter grants a channel g.
  - g is the first nonzero channel at or after last_grant+1, wrapping modulo NUM_EVENTS.
  - last_grant resets to NUM_EVENTS-1, so channel 0 has top priority after reset.
  - Latch paddr = ADDR_BASE+g*ADDR_STRIDE and pwdata = cnt[g].
  - Set cnt[g] <= event_i[g] (snapshot and clear). The same-cycle event is not lost.
  - Go to SETUP.
- SETUP: psel=1, penable=0. Always advances to ACCESS on the next cycle.
- ACCESS: psel=1, penable=1. Stay in ACCESS while pready=0.
  - With pready=1, the transfer completes this cycle.
  - Then go to SETUP if a new grant exists (back-to-back), else IDLE.
- paddr, pwdata and pwrite are stable from SETUP through ACCESS completion.
- Arithmetic: paddr is computed mod 2^32 with no overflow check. pwdata[31:CNT_W]=0.
- Events on non-granted channels keep accumulating during a transfer.

## Timing
- Reset values: psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, ovf_o=0. All cnt=0, state IDLE, last_grant=NUM_EVENTS-1.
- All APB outputs are registered.
- Latency: event_i[k]=1 is sampled at edge E0, so cnt[k]=1 after E0. The grant happens in the IDLE cycle after E0. psel=1 from edge E1, penable=1 from E2. The minimum transfer is 2 cycles.
- Back-to-back: the ACCESS completion cycle is followed directly by SETUP. There is no IDLE bubble.
- Reset asserted mid-transfer: psel and penable drop to 0 asynchronously. Counters and ovf_o clear. No transfer is replayed.
- Simultaneous events on several channels are all counted; the arbiter serves them in round-robin order.
- Saturated channel: pwdata = 2^CNT_W-1 and ovf_o[k] stays 1.

## Structure
- Package event_apb_pkg holds:
  - the state enum apb_state_t {IDLE, SETUP, ACCESS}
  - default ADDR_BASE and ADDR_STRIDE localparams
  - function ch_addr(base, stride, idx)
- Sub-module rr_arbiter, parameter N:
  - inputs: req[N], advance, clk, reset
  - outputs: gnt_idx and gnt_valid
  - holds last_grant internally; updates it only when advance=1
- Top level holds: counters, overflow flags, FSM, APB output registers.

## Test plan
- Single event, pready tied 1: pulse event_i[0] once -> psel high 1 cycle later, then SETUP, ACCESS, back to IDLE. paddr=32'h0000_ABC0, pwdata=1, pwrite=1.
- Wait states: event on ch2 with pready held 0 for 3 ACCESS cycles -> ACCESS lasts 4 cycles. paddr=32'h0000_ABC8 and pwdata=1 stay stable throughout.
- Coalescing and overflow: 20 consecutive event_i[1] cycles while ch0's transfer is stalled with pready=0 -> ch1 writes pwdata=15 (CNT_W=4) and ovf_o[1]=1 stays set.
- Round robin: event_i=3'b111 for one cycle -> writes in order ch0, ch1, ch2, back-to-back with no IDLE between them. Then event_i=3'b101 -> order ch0, ch2.
- Same-cycle event at grant: event_i[0]=1 on the grant cycle of ch0 -> first write pwdata=1, then a second write to ch0 with pwdata=1.
- Reset mid-ACCESS: assert reset while pready=0 -> psel=0, penable=0 immediately and ovf_o=0. The pending event on ch1 is discarded and no write follows the reset release.

Source files
------------

// File: rtl/event_apb_master_rr_pkg.sv
// Shared types and helpers for the event-to-APB write master.
// State encoding, default address map, per-channel address computation.
package event_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam logic [31:0] ADDR_BASE_DEF   = 32'h0000_ABC0;
    localparam logic [31:0] ADDR_STRIDE_DEF = 32'h0000_0004;

    // Wraps modulo 2^32; callers rely on that rather than on any range check.
    function automatic logic [31:0] ch_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] idx);
        return base + stride * idx;
    endfunction

endpackage

// File: rtl/event_apb_master_rr_if.sv
// APB write port of the event master; master drives the request, slave returns ready.
// Signal names match the block's external APB pins.
interface event_apb_master_rr_if;

    logic        apb_psel_o;
    logic        apb_penable_o;
    logic [31:0] apb_paddr_o;
    logic        apb_pwrite_o;
    logic [31:0] apb_pwdata_o;
    logic        apb_pready_i;

    modport master (
        output apb_psel_o,
        output apb_penable_o,
        output apb_paddr_o,
        output apb_pwrite_o,
        output apb_pwdata_o,
        input  apb_pready_i
    );

    modport slave (
        input  apb_psel_o,
        input  apb_penable_o,
        input  apb_paddr_o,
        input  apb_pwrite_o,
        input  apb_pwdata_o,
        output apb_pready_i
    );

endinterface

// File: rtl/event_apb_master_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index.
// Latency: combinational grant; last grant registered on advance.
// Backpressure: the grant is held until the caller asserts advance.
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] r_last;

    // Reset to the top index so channel 0 wins the first arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= IDX_W'(N - 1);
        end else if (advance && gnt_valid) begin
            r_last <= gnt_idx;
        end
    end

    // Two passes: indices above the last grant first, then wrap to the rest.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!gnt_valid && req[j] && (IDX_W'(j) > r_last)) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!gnt_valid && req[j] && (IDX_W'(j) <= r_last)) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/event_apb_master_rr.sv
// Event-to-APB write master: per-channel saturating counters drained round-robin.
// Latency: event sampled at E0 -> psel at E1, penable at E2; 2-cycle minimum write.
// Backpressure: ACCESS holds while pready=0; counters keep accumulating meanwhile.
module event_apb_master_rr
    import event_apb_pkg::*;
#(
    parameter int          NUM_EVENTS  = 3,
    parameter int          CNT_W       = 4,
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
    parameter logic [31:0] ADDR_STRIDE = ADDR_STRIDE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic [NUM_EVENTS-1:0] ovf_o,
    event_apb_master_rr_if.master apb
);

    localparam int               IDX_W   = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]      r_cnt [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] r_ovf;
    logic [NUM_EVENTS-1:0] w_req;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic                  w_gnt_valid;
    logic                  w_advance;
    logic [CNT_W-1:0]      w_gnt_cnt;

    apb_state_t  r_state;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;

    always_comb begin
        w_req     = '0;
        w_gnt_cnt = '0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            w_req[k] = (r_cnt[k] != '0);
            if (w_gnt_idx == IDX_W'(k)) begin
                w_gnt_cnt = r_cnt[k];
            end
        end
    end

    // A new write may start from IDLE or on the completing ACCESS cycle.
    assign w_advance = w_gnt_valid &&
                       ((r_state == IDLE) || ((r_state == ACCESS) && apb.apb_pready_i));

    rr_arbiter #(.N(NUM_EVENTS)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (w_req),
        .advance   (w_advance),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    // Granted channel reloads with this cycle's event so it is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_EVENTS; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (w_advance && (w_gnt_idx == IDX_W'(k))) begin
                    r_cnt[k] <= CNT_W'(event_i[k]);
                end else if (event_i[k]) begin
                    if (r_cnt[k] == CNT_MAX) begin
                        r_ovf[k] <= 1'b1;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else if (w_advance) begin
            r_state   <= SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b1;
            r_paddr   <= ch_addr(ADDR_BASE, ADDR_STRIDE, 32'(w_gnt_idx));
            r_pwdata  <= 32'(w_gnt_cnt);
        end else begin
            case (r_state)
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (apb.apb_pready_i) begin
                        r_state   <= IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign apb.apb_psel_o    = r_psel;
    assign apb.apb_penable_o = r_penable;
    assign apb.apb_pwrite_o  = r_pwrite;
    assign apb.apb_paddr_o   = r_paddr;
    assign apb.apb_pwdata_o  = r_pwdata;
    assign ovf_o             = r_ovf;

endmodule
